mem_access_ctrl: RTL and testbench

Sequencer between the MEM pipeline stage and the data-memory bus. It accepts one load or store per instruction and checks address alignment. For stores it generates byte enables and replicated write data; for loads it runs a req/ack handshake to a variable-latency memory and registers the raw word plus the lane/type info that the load extender consumes. While an access is outstanding it stalls the pipeline, and it reports address and bus-timeout exceptions to the CP0 logic.

---
 rtl/mem_access_ctrl_pkg.sv | 48 ++++
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl_be_gen.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared codes for the MEM-stage memory access controller.
// Load/store type codes and FSM encodings carried over from the legacy header,
// plus the fault cause type and the load alignment rule.
package mem_access_ctrl_pkg;

  // Load type codes
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  // Store type codes
  localparam logic [1:0] ST_SW = 2'd0;
  localparam logic [1:0] ST_SH = 2'd1;
  localparam logic [1:0] ST_SB = 2'd2;

  // FSM state encodings (2-bit, legacy values)
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_BUSY  = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;
  localparam logic [1:0] ENC_FAULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    BUSY  = ENC_BUSY,
    DONE  = ENC_DONE,
    FAULT = ENC_FAULT
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_ADEL = 2'd1,
    FC_ADES = 2'd2,
    FC_BUS  = 2'd3
  } fault_cause_t;

  // Word loads need addr[1:0]==0, halfword loads need addr[0]==0.
  function automatic logic load_misaligned(input logic [2:0] lt,
                                           input logic [1:0] a10);
    case (lt)
      LD_LW:          return (a10 != 2'b00);
      LD_LH, LD_LHU:  return a10[0];
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and memory (slave).
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables (0000 on reads)
//   mem_wdata : lane-replicated write data
//   mem_ack   : acknowledge; mem_rdata valid in the same cycle
//   mem_rdata : read word
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl_be_gen.sv
// Store lane generator (combinational).
//   stype      : store type code
//   addr10     : addr[1:0]
//   wdata_in   : store source register value
//   be         : byte enables for the addressed lanes
//   wdata      : source data replicated across lanes
//   misaligned : store address violates the type's alignment
module be_gen
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  stype,
  input  logic [1:0]  addr10,
  input  logic [31:0] wdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    be         = '0;
    wdata      = '0;
    misaligned = 1'b0;
    case (stype)
      ST_SW: begin
        be         = 4'b1111;
        wdata      = wdata_in;
        misaligned = (addr10 != 2'b00);
      end
      ST_SH: begin
        be         = addr10[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{wdata_in[15:0]}};
        misaligned = addr10[0];
      end
      ST_SB: begin
        be    = 4'b0001 << addr10;
        wdata = {4{wdata_in[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access sequencer.
// Checks alignment, drives one bus transaction per instruction with a req/ack
// handshake and a bounded wait, stalls the pipeline while busy, and reports
// done / address-error / bus-error pulses.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid, req_we   : MEM stage request, 1 = store
//   ltype, stype        : load / store type codes
//   addr, wdata_in      : byte address, store source value
//   stall               : freeze upstream pipeline registers
//   done                : one-cycle successful completion pulse
//   rdata_q, addr10_q,
//   ltype_q             : captured load word and lane/type info
//   exc_adel/ades/bus   : one-cycle fault pulses
//   bus                 : data-memory bus (master side)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [2:0]                ltype,
  input  logic [1:0]                stype,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata_in,
  output logic                      stall,
  output logic                      done,
  output logic [31:0]               rdata_q,
  output logic [1:0]                addr10_q,
  output logic [2:0]                ltype_q,
  output logic                      exc_adel,
  output logic                      exc_ades,
  output logic                      exc_bus,
  mem_access_ctrl_if.master         bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t       state;
  fault_cause_t cause;
  logic [CW-1:0] wait_cnt;

  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_wdata_r;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        st_misaligned;
  logic        misaligned;

  be_gen u_be_gen (
    .stype      (stype),
    .addr10     (addr[1:0]),
    .wdata_in   (wdata_in),
    .be         (st_be),
    .wdata      (st_wdata),
    .misaligned (st_misaligned)
  );

  assign misaligned = req_we ? st_misaligned : load_misaligned(ltype, addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cause       <= FC_NONE;
      wait_cnt    <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_be_r    <= '0;
      mem_wdata_r <= '0;
      rdata_q     <= '0;
      addr10_q    <= '0;
      ltype_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              state <= FAULT;
              cause <= req_we ? FC_ADES : FC_ADEL;
            end else begin
              state       <= BUSY;
              cause       <= FC_NONE;
              wait_cnt    <= '0;
              mem_we_r    <= req_we;
              mem_addr_r  <= {addr[31:2], 2'b00};
              mem_be_r    <= req_we ? st_be : 4'b0000;
              mem_wdata_r <= req_we ? st_wdata : 32'd0;
              addr10_q    <= addr[1:0];
              ltype_q     <= ltype;
            end
          end
        end
        BUSY: begin
          // An ack in the timeout cycle still wins over the bus error.
          if (bus.mem_ack) begin
            state <= DONE;
            if (!mem_we_r) rdata_q <= bus.mem_rdata;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state <= FAULT;
            cause <= FC_BUS;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state, so reset removes mem_req asynchronously.
  assign bus.mem_req   = (state == BUSY);
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;

  assign done     = (state == DONE);
  assign exc_adel = (state == FAULT) && (cause == FC_ADEL);
  assign exc_ades = (state == FAULT) && (cause == FC_ADES);
  assign exc_bus  = (state == FAULT) && (cause == FC_BUS);

  assign stall = req_valid && (state != DONE) && (state != FAULT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stores, loads, alignment faults,
// bus timeout (and ack exactly at the timeout), and reset mid-access.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  ltype;
  logic [1:0]  stype;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        stall;
  logic        done;
  logic [31:0] rdata_q;
  logic [1:0]  addr10_q;
  logic [2:0]  ltype_q;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_bus;

  int unsigned passed = 0;
  int unsigned total  = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .ltype     (ltype),
    .stype     (stype),
    .addr      (addr),
    .wdata_in  (wdata_in),
    .stall     (stall),
    .done      (done),
    .rdata_q   (rdata_q),
    .addr10_q  (addr10_q),
    .ltype_q   (ltype_q),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades),
    .exc_bus   (exc_bus),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    ltype     = lt;
    stype     = st;
    addr      = a;
    wdata_in  = wd;
  endtask

  task automatic no_faults(input string tag);
    chk1({tag, "_adel"}, exc_adel, 1'b0);
    chk1({tag, "_ades"}, exc_ades, 1'b0);
    chk1({tag, "_bus"},  exc_bus,  1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    ltype         = LD_LW;
    stype         = ST_SW;
    addr          = '0;
    wdata_in      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    @(negedge clk);
    @(negedge clk);
    chk1 ("rst_req",    bus.mem_req, 1'b0);
    chk1 ("rst_we",     bus.mem_we,  1'b0);
    chk32("rst_addr",   bus.mem_addr, 32'd0);
    chk32("rst_be",     {28'd0, bus.mem_be}, 32'd0);
    chk32("rst_wdata",  bus.mem_wdata, 32'd0);
    chk32("rst_rdata",  rdata_q, 32'd0);
    chk1 ("rst_done",   done, 1'b0);
    chk1 ("rst_stall",  stall, 1'b0);
    no_faults("rst");
    reset = 1'b0;
    tick();

    // sw 0x10, ack on first BUSY cycle
    issue(1'b1, LD_LW, ST_SW, 32'h10, 32'h1234_5678);
    #1 chk1("sw_stall0", stall, 1'b1);
    chk1("sw_req0", bus.mem_req, 1'b0);
    tick();
    chk1 ("sw_req1",   bus.mem_req, 1'b1);
    chk1 ("sw_stall1", stall, 1'b1);
    chk1 ("sw_we",     bus.mem_we, 1'b1);
    chk32("sw_be",     {28'd0, bus.mem_be}, 32'h0000_000F);
    chk32("sw_addr",   bus.mem_addr, 32'h10);
    chk32("sw_wdata",  bus.mem_wdata, 32'h1234_5678);
    bus.mem_ack = 1'b1;
    tick();
    chk1("sw_done",   done, 1'b1);
    chk1("sw_stall2", stall, 1'b0);
    chk1("sw_req2",   bus.mem_req, 1'b0);
    no_faults("sw");
    req_valid   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    chk1("sw_done_end", done, 1'b0);

    // sb 0x13
    issue(1'b1, LD_LW, ST_SB, 32'h13, 32'h0000_00AB);
    tick();
    chk32("sb_be",    {28'd0, bus.mem_be}, 32'h0000_0008);
    chk32("sb_wdata", bus.mem_wdata, 32'hABAB_ABAB);
    chk32("sb_addr",  bus.mem_addr, 32'h10);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk1 ("sb_done",  done, 1'b1);
    chk32("sb_rdata", rdata_q, 32'd0);
    req_valid   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    // sh 0x06 lanes
    issue(1'b1, LD_LW, ST_SH, 32'h106, 32'hFFFF_BEEF);
    tick();
    chk32("sh_be",    {28'd0, bus.mem_be}, 32'h0000_000C);
    chk32("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    bus.mem_ack = 1'b1;
    tick();
    chk1("sh_done", done, 1'b1);
    req_valid   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    // lh 0x22, ack 3 cycles after mem_req rises
    issue(1'b0, LD_LH, ST_SW, 32'h22, 32'h5555_5555);
    tick();
    chk1 ("lh_req1", bus.mem_req, 1'b1);
    chk32("lh_be",   {28'd0, bus.mem_be}, 32'd0);
    chk32("lh_addr", bus.mem_addr, 32'h20);
    chk1 ("lh_we",   bus.mem_we, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("lh_wait_req",  bus.mem_req, 1'b1);
      chk1("lh_wait_done", done, 1'b0);
      chk1("lh_wait_stall", stall, 1'b1);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8001_7FFF;
    tick();
    chk1 ("lh_done",   done, 1'b1);
    chk32("lh_rdata",  rdata_q, 32'h8001_7FFF);
    chk32("lh_a10",    {30'd0, addr10_q}, 32'd2);
    chk32("lh_ltype",  {29'd0, ltype_q}, {29'd0, LD_LH});
    no_faults("lh");
    req_valid     = 1'b0;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    // stray ack in IDLE
    chk1 ("idle_ack_req",  bus.mem_req, 1'b0);
    chk1 ("idle_ack_done", done, 1'b0);
    tick();
    chk32("idle_ack_rdata", rdata_q, 32'h8001_7FFF);
    bus.mem_ack = 1'b0;

    // lw 0x05 misaligned
    issue(1'b0, LD_LW, ST_SW, 32'h05, 32'd0);
    #1 chk1("lwmis_stall0", stall, 1'b1);
    tick();
    chk1("lwmis_adel",  exc_adel, 1'b1);
    chk1("lwmis_ades",  exc_ades, 1'b0);
    chk1("lwmis_bus",   exc_bus, 1'b0);
    chk1("lwmis_req",   bus.mem_req, 1'b0);
    chk1("lwmis_stall", stall, 1'b0);
    req_valid = 1'b0;
    tick();
    chk1("lwmis_adel_end", exc_adel, 1'b0);
    chk1("lwmis_req_end",  bus.mem_req, 1'b0);

    // sh 0x07 misaligned
    issue(1'b1, LD_LW, ST_SH, 32'h07, 32'd0);
    tick();
    chk1("shmis_ades", exc_ades, 1'b1);
    chk1("shmis_adel", exc_adel, 1'b0);
    chk1("shmis_req",  bus.mem_req, 1'b0);
    req_valid = 1'b0;
    tick();
    chk1("shmis_ades_end", exc_ades, 1'b0);

    // lhu 0x21 misaligned
    issue(1'b0, LD_LHU, ST_SW, 32'h21, 32'd0);
    tick();
    chk1("lhumis_adel", exc_adel, 1'b1);
    req_valid = 1'b0;
    tick();

    // lw timeout: 16 BUSY cycles then bus error
    issue(1'b0, LD_LW, ST_SW, 32'h40, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk1("to_busy_req", bus.mem_req, 1'b1);
      chk1("to_busy_bus", exc_bus, 1'b0);
    end
    tick();
    chk1("to_bus",   exc_bus, 1'b1);
    chk1("to_adel",  exc_adel, 1'b0);
    chk1("to_req",   bus.mem_req, 1'b0);
    chk1("to_done",  done, 1'b0);
    chk1("to_stall", stall, 1'b0);
    req_valid = 1'b0;
    tick();
    chk1("to_bus_end", exc_bus, 1'b0);

    // ack in the timeout cycle is a success
    issue(1'b0, LD_LW, ST_SW, 32'h44, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    tick();
    chk1("tb_last_req", bus.mem_req, 1'b1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    chk1 ("tb_done",  done, 1'b1);
    chk1 ("tb_bus",   exc_bus, 1'b0);
    chk32("tb_rdata", rdata_q, 32'hCAFE_F00D);
    req_valid   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    // reset during BUSY
    issue(1'b0, LD_LW, ST_SW, 32'h48, 32'd0);
    tick();
    chk1("rb_req_pre", bus.mem_req, 1'b1);
    #1 reset = 1'b1;
    #1 chk1("rb_req_async", bus.mem_req, 1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk1 ("rb_done",  done, 1'b0);
    chk32("rb_rdata", rdata_q, 32'd0);
    no_faults("rb");
    tick();
    chk1("rb_done2", done, 1'b0);
    no_faults("rb2");
    issue(1'b1, LD_LW, ST_SW, 32'h50, 32'hA5A5_0F0F);
    tick();
    chk1 ("rb_new_req",   bus.mem_req, 1'b1);
    chk32("rb_new_wdata", bus.mem_wdata, 32'hA5A5_0F0F);
    bus.mem_ack = 1'b1;
    tick();
    chk1("rb_new_done", done, 1'b1);
    req_valid   = 1'b0;
    bus.mem_ack = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
